right_shift_16bit_seq: RTL and testbench



---
 rtl/right_shift_16bit_seq.sv | 94 +++++++++
 tb/tb_right_shift_16bit_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/right_shift_16bit_seq.sv
// Multi-cycle 16-bit right shifter: logical, arithmetic or rotate, one bit
// position per clock, driven by a start/busy/done handshake. The result and
// the last bit shifted out are registered and hold until the next completion.
module right_shift_16bit_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] in,
  input  logic [3:0]  shift,
  input  logic [1:0]  mode,
  output logic        busy,
  output logic        done,
  output logic [15:0] out,
  output logic        carry_out
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  // Mode 2'b11 has no dedicated meaning and falls through to logical fill.
  typedef enum logic [1:0] {
    MODE_LOGICAL  = 2'b00,
    MODE_ARITH    = 2'b01,
    MODE_ROTATE   = 2'b10,
    MODE_RESERVED = 2'b11
  } shmode_t;

  state_t      state;
  shmode_t     mode_q;
  logic [15:0] work;
  logic [3:0]  cnt;
  logic        fill;
  logic [15:0] shifted;

  // Fill bit entering at the MSB for the current one-position shift.
  always_comb begin
    fill = 1'b0;
    case (mode_q)
      MODE_ARITH:  fill = work[15];
      MODE_ROTATE: fill = work[0];
      default:     fill = 1'b0;
    endcase
    shifted = {fill, work[15:1]};
  end

  // Handshake FSM, working register, counter and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= MODE_LOGICAL;
      work      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out       <= '0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (shift == 4'd0) begin
              // A zero shift completes on the accept edge itself.
              out       <= in;
              carry_out <= 1'b0;
              done      <= 1'b1;
            end else begin
              work   <= in;
              cnt    <= shift;
              mode_q <= shmode_t'(mode);
              busy   <= 1'b1;
              state  <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            out       <= shifted;
            carry_out <= work[0];
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_right_shift_16bit_seq.sv
// Directed testbench for right_shift_16bit_seq with hand-computed vectors.
module tb_right_shift_16bit_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] in;
  logic [3:0]  shift;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        carry_out;

  int unsigned passed;
  int unsigned total;

  // Bench-side copy of the expected held result.
  logic [15:0] last_out;
  logic        last_c;

  right_shift_16bit_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in        (in),
    .shift     (shift),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .out       (out),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Launch one operation and follow it to completion. If glitch > 0, a
  // different request is presented during the cycle after edge E_glitch.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [3:0] n,
                        input logic [1:0] m, input logic [15:0] exp_out,
                        input logic exp_c, input int unsigned glitch);
    in    = a;
    shift = n;
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;  // E0
    start = 1'b0;
    in    = 16'h5A5A;
    shift = 4'd7;
    mode  = 2'b01;
    if (n == 4'd0) begin
      chk({tag, "_done"}, {15'd0, done}, 16'd1);
      chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
    end else begin
      for (int unsigned k = 0; k < n; k++) begin
        // k cycles after E0: still shifting, nothing published yet
        chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
        chk({tag, "_nodone"}, {15'd0, done}, 16'd0);
        chk({tag, "_hold"}, out, last_out);
        chk({tag, "_holdc"}, {15'd0, carry_out}, {15'd0, last_c});
        start = (glitch != 0 && k == glitch) ? 1'b1 : 1'b0;
        if (start) begin
          in    = 16'hFFFF;
          shift = 4'd1;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
      chk({tag, "_done"}, {15'd0, done}, 16'd1);
      chk({tag, "_busyoff"}, {15'd0, busy}, 16'd0);
    end
    chk({tag, "_out"}, out, exp_out);
    chk({tag, "_c"}, {15'd0, carry_out}, {15'd0, exp_c});
    last_out = exp_out;
    last_c   = exp_c;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    last_out = 16'h0000;
    last_c   = 1'b0;
    rst      = 1'b1;
    start    = 1'b0;
    in       = 16'h0000;
    shift    = 4'd0;
    mode     = 2'b00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_out", out, 16'h0000);
    chk("rst_c", {15'd0, carry_out}, 16'd0);
    rst = 1'b0;

    run_op("lsr4", 16'h8001, 4'd4, 2'b00, 16'h0800, 1'b0, 0);
    @(posedge clk); #1;
    chk("lsr4_pulse", {15'd0, done}, 16'd0);

    run_op("asr15n", 16'h8000, 4'd15, 2'b01, 16'hFFFF, 1'b0, 0);
    run_op("asr15p", 16'h7FFF, 4'd15, 2'b01, 16'h0000, 1'b1, 0);
    run_op("ror1", 16'h0001, 4'd1, 2'b10, 16'h8000, 1'b1, 0);
    run_op("ror8", 16'h1234, 4'd8, 2'b10, 16'h3412, 1'b0, 0);
    run_op("mode3", 16'h8000, 4'd1, 2'b11, 16'h4000, 1'b0, 0);

    // Zero shift followed by a start issued in the done cycle.
    run_op("zero", 16'hABCD, 4'd0, 2'b00, 16'hABCD, 1'b0, 0);
    run_op("b2b", 16'h00F0, 4'd4, 2'b00, 16'h000F, 1'b0, 0);

    // Start pulsed mid-operation must be ignored.
    run_op("ign", 16'hF0F0, 4'd8, 2'b00, 16'h00F0, 1'b1, 3);
    for (int unsigned k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("ign_nodone", {15'd0, done}, 16'd0);
      chk("ign_idle", {15'd0, busy}, 16'd0);
      chk("ign_out", out, 16'h00F0);
    end

    // Asynchronous reset in the middle of a 10-bit shift.
    in    = 16'hFFFF;
    shift = 4'd10;
    mode  = 2'b00;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_done", {15'd0, done}, 16'd0);
    chk("arst_out", out, 16'h0000);
    chk("arst_c", {15'd0, carry_out}, 16'd0);
    last_out = 16'h0000;
    last_c   = 1'b0;
    for (int unsigned k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("arst_nodone", {15'd0, done}, 16'd0);
    end
    rst = 1'b0;
    for (int unsigned k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("post_rst_nodone", {15'd0, done}, 16'd0);
      chk("post_rst_idle", {15'd0, busy}, 16'd0);
    end
    run_op("fresh", 16'h0004, 4'd2, 2'b00, 16'h0001, 1'b0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
